// File: rtl/model_algebra_matrix_stimulus_if.sv
// rtl/model_algebra_matrix_stimulus_if.sv - run request, stimulus stream and DUT handshake bundle
interface model_algebra_matrix_stimulus_if #(
  parameter int DATA_SIZE = 64
);
  logic                 GO;
  logic [1:0]           MODE;
  logic [DATA_SIZE-1:0] SIZE_I_IN;
  logic [DATA_SIZE-1:0] SIZE_J_IN;
  logic [DATA_SIZE-1:0] SEED_IN;
  logic                 DUT_READY;
  logic                 START;
  logic                 DATA_IN_I_ENABLE;
  logic                 DATA_IN_J_ENABLE;
  logic [DATA_SIZE-1:0] DATA_OUT;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    output GO, MODE, SIZE_I_IN, SIZE_J_IN, SEED_IN, DUT_READY,
    input  START, DATA_IN_I_ENABLE, DATA_IN_J_ENABLE, DATA_OUT, BUSY, DONE
  );

  modport slave (
    input  GO, MODE, SIZE_I_IN, SIZE_J_IN, SEED_IN, DUT_READY,
    output START, DATA_IN_I_ENABLE, DATA_IN_J_ENABLE, DATA_OUT, BUSY, DONE
  );
endinterface

// File: rtl/model_algebra_matrix_stimulus.sv
// rtl/model_algebra_matrix_stimulus.sv - row-major matrix stimulus generator for an algebra DUT
// Optional MODE 3 LFSR pattern enabled by MODEL_ALGEBRA_STIMULUS_LFSR_EN.
module model_algebra_matrix_stimulus #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                               CLK,
  input  logic                               RST,
  model_algebra_matrix_stimulus_if.slave     bus
);
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STARTING   = 2'd1,
    STREAM     = 2'd2,
    WAIT_READY = 2'd3
  } state_t;

  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_IDENT = 2'd2;
  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

  // Control width is reserved for sibling-block compatibility; nothing here consumes it.
  if (CONTROL_SIZE > 0) begin : g_ctrl_reserved
  end

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [DATA_SIZE-1:0] size_i_q, size_i_d;
  logic [DATA_SIZE-1:0] size_j_q, size_j_d;
  logic [DATA_SIZE-1:0] seed_q, seed_d;
  logic [DATA_SIZE-1:0] i_q, i_d;
  logic [DATA_SIZE-1:0] j_q, j_d;
  logic [DATA_SIZE-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
`ifdef MODEL_ALGEBRA_STIMULUS_LFSR_EN
  logic [DATA_SIZE-1:0] lfsr_q, lfsr_d;
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    size_i_d = size_i_q;
    size_j_d = size_j_q;
    seed_d   = seed_q;
    i_d      = i_q;
    j_d      = j_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef MODEL_ALGEBRA_STIMULUS_LFSR_EN
    lfsr_d   = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.GO) begin
          if ((bus.SIZE_I_IN != '0) && (bus.SIZE_J_IN != '0)) begin
            mode_d   = bus.MODE;
            size_i_d = bus.SIZE_I_IN;
            size_j_d = bus.SIZE_J_IN;
            seed_d   = bus.SEED_IN;
            i_d      = '0;
            j_d      = '0;
            cnt_d    = '0;
`ifdef MODEL_ALGEBRA_STIMULUS_LFSR_EN
            lfsr_d   = (bus.SEED_IN == '0) ? ONE : bus.SEED_IN;
`endif
            state_d  = STARTING;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STARTING: state_d = STREAM;
      STREAM: begin
        // The running counter equals i*J+j modulo 2^DATA_SIZE without a multiplier.
        cnt_d = cnt_q + ONE;
`ifdef MODEL_ALGEBRA_STIMULUS_LFSR_EN
        lfsr_d = {lfsr_q[DATA_SIZE-2:0], lfsr_q[DATA_SIZE-1] ^ lfsr_q[DATA_SIZE-2]};
`endif
        if (j_q == size_j_q - ONE) begin
          j_d = '0;
          if (i_q == size_i_q - ONE) begin
            i_d     = '0;
            state_d = WAIT_READY;
          end else begin
            i_d = i_q + ONE;
          end
        end else begin
          j_d = j_q + ONE;
        end
      end
      WAIT_READY: begin
        if (bus.DUT_READY) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      size_i_q <= '0;
      size_j_q <= '0;
      seed_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef MODEL_ALGEBRA_STIMULUS_LFSR_EN
      lfsr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      size_i_q <= size_i_d;
      size_j_q <= size_j_d;
      seed_q   <= seed_d;
      i_q      <= i_d;
      j_q      <= j_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
`ifdef MODEL_ALGEBRA_STIMULUS_LFSR_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  logic                 streaming;
  logic [DATA_SIZE-1:0] elem;

  always_comb begin
    case (mode_q)
      MODE_CONST: elem = seed_q;
      MODE_IDENT: elem = (i_q == j_q) ? ONE : '0;
`ifdef MODEL_ALGEBRA_STIMULUS_LFSR_EN
      2'd3:       elem = lfsr_q;
`endif
      default:    elem = cnt_q;
    endcase
  end

  // Outputs are gated by RST so they read zero during the reset cycle itself.
  assign streaming            = (state_q == STREAM) && !RST;
  assign bus.START            = (state_q == STARTING) && !RST;
  assign bus.BUSY             = (state_q != IDLE) && !RST;
  assign bus.DONE             = done_q && !RST;
  assign bus.DATA_IN_J_ENABLE = streaming;
  assign bus.DATA_IN_I_ENABLE = streaming && (j_q == '0);
  assign bus.DATA_OUT         = streaming ? elem : '0;
endmodule

// File: tb/tb_model_algebra_matrix_stimulus.sv
// tb/tb_model_algebra_matrix_stimulus.sv - directed table-driven bench for the matrix stimulus block
module tb_model_algebra_matrix_stimulus;
  localparam int DW = 8;

  logic CLK;
  logic RST;
  int   tests;
  int   fails;

  model_algebra_matrix_stimulus_if #(.DATA_SIZE(DW)) bus ();

  model_algebra_matrix_stimulus #(.DATA_SIZE(DW), .CONTROL_SIZE(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]      mode;
    logic [7:0]      si;
    logic [7:0]      sj;
    logic [7:0]      seed;
    logic [3:0]      n;
    logic [8:0][7:0] exp;
    logic [8:0]      ien;
  } vec_t;

  vec_t vec [5];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, ".start"}, 32'(bus.START), 32'd0);
    chk({name, ".jen"},   32'(bus.DATA_IN_J_ENABLE), 32'd0);
    chk({name, ".ien"},   32'(bus.DATA_IN_I_ENABLE), 32'd0);
    chk({name, ".data"},  32'(bus.DATA_OUT), 32'd0);
  endtask

  task automatic run_vec(input int idx, input bit poke);
    vec_t v;
    v = vec[idx];
    bus.MODE      = v.mode;
    bus.SIZE_I_IN = v.si;
    bus.SIZE_J_IN = v.sj;
    bus.SEED_IN   = v.seed;
    bus.GO        = 1'b1;
    tick();
    bus.GO = 1'b0;
    chk($sformatf("v%0d.start", idx), 32'(bus.START), 32'd1);
    chk($sformatf("v%0d.busy", idx),  32'(bus.BUSY), 32'd1);
    chk($sformatf("v%0d.jen0", idx),  32'(bus.DATA_IN_J_ENABLE), 32'd0);
    for (int k = 0; k < int'(v.n); k++) begin
      // Stray GO and DUT_READY sampled mid-stream must not disturb the run.
      if (poke && k == 2) begin
        bus.GO        = 1'b1;
        bus.DUT_READY = 1'b1;
        bus.SIZE_I_IN = 8'd1;
        bus.MODE      = 2'd1;
      end
      tick();
      bus.GO        = 1'b0;
      bus.DUT_READY = 1'b0;
      chk($sformatf("v%0d.e%0d.jen", idx, k),  32'(bus.DATA_IN_J_ENABLE), 32'd1);
      chk($sformatf("v%0d.e%0d.ien", idx, k),  32'(bus.DATA_IN_I_ENABLE), 32'(v.ien[k]));
      chk($sformatf("v%0d.e%0d.data", idx, k), 32'(bus.DATA_OUT), 32'(v.exp[k]));
      chk($sformatf("v%0d.e%0d.busy", idx, k), 32'(bus.BUSY), 32'd1);
    end
    for (int w = 0; w < 3; w++) begin
      tick();
      chk_quiet($sformatf("v%0d.wait%0d", idx, w));
      chk($sformatf("v%0d.wait%0d.busy", idx, w), 32'(bus.BUSY), 32'd1);
      chk($sformatf("v%0d.wait%0d.done", idx, w), 32'(bus.DONE), 32'd0);
    end
    bus.DUT_READY = 1'b1;
    tick();
    bus.DUT_READY = 1'b0;
    chk($sformatf("v%0d.done", idx),      32'(bus.DONE), 32'd1);
    chk($sformatf("v%0d.idle_busy", idx), 32'(bus.BUSY), 32'd0);
    tick();
    chk($sformatf("v%0d.done_clr", idx),  32'(bus.DONE), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    vec[0] = '{mode: 2'd0, si: 8'd2, sj: 8'd3, seed: 8'h00, n: 4'd6,
               exp: {8'd0, 8'd0, 8'd0, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
               ien: 9'b000001001};
    vec[1] = '{mode: 2'd2, si: 8'd3, sj: 8'd3, seed: 8'h00, n: 4'd9,
               exp: {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1},
               ien: 9'b001001001};
    vec[2] = '{mode: 2'd1, si: 8'd1, sj: 8'd2, seed: 8'h5A, n: 4'd2,
               exp: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h5A, 8'h5A},
               ien: 9'b000000001};
`ifdef MODEL_ALGEBRA_STIMULUS_LFSR_EN
    vec[3] = '{mode: 2'd3, si: 8'd1, sj: 8'd3, seed: 8'h00, n: 4'd3,
               exp: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h04, 8'h02, 8'h01},
               ien: 9'b000000001};
`else
    vec[3] = '{mode: 2'd3, si: 8'd1, sj: 8'd3, seed: 8'h00, n: 4'd3,
               exp: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd1, 8'd0},
               ien: 9'b000000001};
`endif
    vec[4] = '{mode: 2'd0, si: 8'd3, sj: 8'd1, seed: 8'h00, n: 4'd3,
               exp: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd1, 8'd0},
               ien: 9'b000000111};

    bus.GO        = 1'b0;
    bus.MODE      = 2'd0;
    bus.SIZE_I_IN = '0;
    bus.SIZE_J_IN = '0;
    bus.SEED_IN   = '0;
    bus.DUT_READY = 1'b0;
    RST           = 1'b1;

    // GO coincident with reset is dropped.
    bus.GO        = 1'b1;
    bus.SIZE_I_IN = 8'd2;
    bus.SIZE_J_IN = 8'd2;
    tick();
    tick();
    chk_quiet("rst");
    chk("rst.busy", 32'(bus.BUSY), 32'd0);
    chk("rst.done", 32'(bus.DONE), 32'd0);
    bus.GO = 1'b0;
    RST    = 1'b0;
    tick();
    chk("rst_go.busy", 32'(bus.BUSY), 32'd0);

    for (int v = 0; v < 5; v++) run_vec(v, 1'b0);

    // Zero-sized request completes immediately without touching the DUT.
    bus.SIZE_I_IN = 8'd0;
    bus.SIZE_J_IN = 8'd4;
    bus.GO        = 1'b1;
    tick();
    bus.GO = 1'b0;
    chk("zero.done", 32'(bus.DONE), 32'd1);
    chk("zero.busy", 32'(bus.BUSY), 32'd0);
    chk_quiet("zero");
    tick();
    chk("zero.done_clr", 32'(bus.DONE), 32'd0);
    chk("zero.busy2", 32'(bus.BUSY), 32'd0);
    chk_quiet("zero2");

    // Reset in the middle of a 4x4 constant run.
    bus.MODE      = 2'd1;
    bus.SIZE_I_IN = 8'd4;
    bus.SIZE_J_IN = 8'd4;
    bus.SEED_IN   = 8'hA5;
    bus.GO        = 1'b1;
    tick();
    bus.GO = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst.e2.data", 32'(bus.DATA_OUT), 32'hA5);
    RST = 1'b1;
    #1;
    chk_quiet("midrst.during");
    tick();
    RST = 1'b0;
    chk_quiet("midrst.after");
    chk("midrst.busy", 32'(bus.BUSY), 32'd0);
    chk("midrst.done", 32'(bus.DONE), 32'd0);
    tick();
    chk_quiet("midrst.idle");
    chk("midrst.idle_busy", 32'(bus.BUSY), 32'd0);

    // Clean restart, with stray GO and DUT_READY injected mid-stream.
    run_vec(0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end
endmodule
